// File: rtl/writeback_arbiter_if.sv
// Writeback merger bundle: per-channel execute results in, one shared commit port out.
interface writeback_arbiter_if #(
  parameter int N_IN   = 2,
  parameter int DATA_W = 32,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 6
);
  logic [N_IN-1:0]        in_valid;
  logic [N_IN-1:0]        in_ready;
  logic [N_IN*ROB_W-1:0]  in_rob_id;
  logic [N_IN-1:0]        in_wen;
  logic [N_IN*PREG_W-1:0] in_preg;
  logic [N_IN*DATA_W-1:0] in_data;
  logic                   flush;
  logic [ROB_W-1:0]       next_retire_id;

  logic                   rf_wen;
  logic [PREG_W-1:0]      rf_addr;
  logic [DATA_W-1:0]      rf_data;
  logic                   rt_wen;
  logic [PREG_W-1:0]      rt_addr;
  logic                   rt_data;
  logic                   wk_valid;
  logic [PREG_W-1:0]      wk_preg;
  logic                   rob_valid;
  logic [ROB_W-1:0]       rob_id;

  modport master (
    output in_valid, in_rob_id, in_wen, in_preg, in_data, flush, next_retire_id,
    input  in_ready, rf_wen, rf_addr, rf_data, rt_wen, rt_addr, rt_data,
           wk_valid, wk_preg, rob_valid, rob_id
  );

  modport slave (
    input  in_valid, in_rob_id, in_wen, in_preg, in_data, flush, next_retire_id,
    output in_ready, rf_wen, rf_addr, rf_data, rt_wen, rt_addr, rt_data,
           wk_valid, wk_preg, rob_valid, rob_id
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges N_IN buffered execute results onto one registered writeback port,
// round-robin or oldest-first by ROB age, with flush support.
module writeback_arbiter #(
  parameter int N_IN     = 2,
  parameter int DEPTH    = 2,
  parameter int DATA_W   = 32,
  parameter int PREG_W   = 6,
  parameter int ROB_W    = 6,
  parameter int ARB_MODE = 0
) (
  input logic              clk,
  input logic              rst,
  writeback_arbiter_if.slave wb
);

  localparam int IDX_W = $clog2(N_IN);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ROB_W + 1 + PREG_W + DATA_W;

  logic [ENT_W-1:0] mem    [N_IN][DEPTH];
  logic [PTR_W-1:0] wr_ptr [N_IN];
  logic [PTR_W-1:0] rd_ptr [N_IN];
  logic [CNT_W-1:0] count  [N_IN];
  logic [ENT_W-1:0] head   [N_IN];
  logic [ROB_W-1:0] head_id[N_IN];
  logic [N_IN-1:0]  nonempty;
  logic [N_IN-1:0]  push;
  logic [N_IN-1:0]  pop;
  logic [IDX_W-1:0] rr_ptr;

  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] cand;
  logic [ROB_W-1:0] age;
  logic [ROB_W-1:0] best_age;
  logic [ENT_W-1:0] gnt_ent;
  logic [ROB_W-1:0] gnt_id;
  logic             gnt_wen;
  logic [PREG_W-1:0] gnt_preg;
  logic [DATA_W-1:0] gnt_data;
  logic             gnt_wr;

  // Ready comes from registered count only, so sources never see a comb path from valid.
  always_comb begin
    wb.in_ready = '0;
    nonempty    = '0;
    push        = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      wb.in_ready[i] = !rst && (count[i] < CNT_W'(DEPTH));
      nonempty[i]    = (count[i] != '0);
      push[i]        = wb.in_valid[i] && wb.in_ready[i];
      head[i]        = mem[i][rd_ptr[i]];
      head_id[i]     = head[i][ENT_W-1 -: ROB_W];
    end
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    age       = '0;
    best_age  = '0;
    if (ARB_MODE == 0) begin
      for (int unsigned k = 1; k <= N_IN; k++) begin
        cand = IDX_W'((int'(rr_ptr) + int'(k)) % N_IN);
        if (!gnt_valid && nonempty[cand]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand;
        end
      end
    end else begin
      // Age wraps mod 2^ROB_W; strict compare keeps the lowest index on ties.
      for (int unsigned i = 0; i < N_IN; i++) begin
        age = head_id[i] - wb.next_retire_id;
        if (nonempty[i] && (!gnt_valid || age < best_age)) begin
          gnt_valid = 1'b1;
          gnt_idx   = IDX_W'(i);
          best_age  = age;
        end
      end
    end
    gnt_ent  = head[gnt_idx];
    gnt_id   = gnt_ent[ENT_W-1 -: ROB_W];
    gnt_wen  = gnt_ent[DATA_W + PREG_W];
    gnt_preg = gnt_ent[DATA_W +: PREG_W];
    gnt_data = gnt_ent[DATA_W-1:0];
    gnt_wr   = gnt_valid && gnt_wen && (gnt_preg != '0);
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < N_IN; i++)
      pop[i] = gnt_valid && (gnt_idx == IDX_W'(i));
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_IN; i++)
      if (push[i])
        mem[i][wr_ptr[i]] <= {wb.in_rob_id[i*ROB_W +: ROB_W], wb.in_wen[i],
                              wb.in_preg[i*PREG_W +: PREG_W], wb.in_data[i*DATA_W +: DATA_W]};
  end

  always_ff @(posedge clk) begin
    if (rst || wb.flush) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      if (rst) rr_ptr <= IDX_W'(N_IN - 1);
      wb.rob_valid <= 1'b0;
      wb.rob_id    <= '0;
      wb.rf_wen    <= 1'b0;
      wb.rf_addr   <= '0;
      wb.rf_data   <= '0;
      wb.rt_wen    <= 1'b0;
      wb.rt_addr   <= '0;
      wb.rt_data   <= 1'b0;
      wb.wk_valid  <= 1'b0;
      wb.wk_preg   <= '0;
    end else begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
        if (pop[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (pop[i] && !push[i]) count[i] <= count[i] - 1'b1;
      end
      if (gnt_valid) rr_ptr <= gnt_idx;
      wb.rob_valid <= gnt_valid;
      wb.rob_id    <= gnt_valid ? gnt_id : '0;
      wb.rf_wen    <= gnt_wr;
      wb.rf_addr   <= gnt_wr ? gnt_preg : '0;
      wb.rf_data   <= gnt_wr ? gnt_data : '0;
      wb.rt_wen    <= gnt_wr;
      wb.rt_addr   <= gnt_wr ? gnt_preg : '0;
      wb.rt_data   <= gnt_wr;
      wb.wk_valid  <= gnt_wr;
      wb.wk_preg   <= gnt_wr ? gnt_preg : '0;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: a round-robin and an oldest-first instance share
// stimulus and are checked against a queue-based reference model.
module tb_writeback_arbiter;

  localparam int N = 3;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  v, wen;
  logic [17:0] rid, preg;
  logic [95:0] data;
  logic        flush;
  logic [5:0]  nri;

  writeback_arbiter_if #(.N_IN(3), .DATA_W(32), .PREG_W(6), .ROB_W(6)) ifr ();
  writeback_arbiter_if #(.N_IN(3), .DATA_W(32), .PREG_W(6), .ROB_W(6)) ifa ();

  assign ifr.in_valid = v;    assign ifa.in_valid = v;
  assign ifr.in_rob_id = rid; assign ifa.in_rob_id = rid;
  assign ifr.in_wen = wen;    assign ifa.in_wen = wen;
  assign ifr.in_preg = preg;  assign ifa.in_preg = preg;
  assign ifr.in_data = data;  assign ifa.in_data = data;
  assign ifr.flush = flush;   assign ifa.flush = flush;
  assign ifr.next_retire_id = nri; assign ifa.next_retire_id = nri;

  writeback_arbiter #(.N_IN(3), .DEPTH(2), .DATA_W(32), .PREG_W(6), .ROB_W(6), .ARB_MODE(0))
    dut_rr (.clk(clk), .rst(rst), .wb(ifr));
  writeback_arbiter #(.N_IN(3), .DEPTH(2), .DATA_W(32), .PREG_W(6), .ROB_W(6), .ARB_MODE(1))
    dut_age (.clk(clk), .rst(rst), .wb(ifa));

  // Observed port words; data fields only matter when their write enable is set.
  logic [63:0] obs_w[2], raw_w[2];
  assign obs_w[0] = {3'b0, ifr.rob_valid, ifr.rob_valid ? ifr.rob_id : 6'h0, ifr.rf_wen, ifr.rt_wen,
                     ifr.rt_wen ? ifr.rt_data : 1'b0, ifr.wk_valid, ifr.rf_addr, ifr.rt_addr,
                     ifr.wk_preg, ifr.rf_wen ? ifr.rf_data : 32'h0};
  assign obs_w[1] = {3'b0, ifa.rob_valid, ifa.rob_valid ? ifa.rob_id : 6'h0, ifa.rf_wen, ifa.rt_wen,
                     ifa.rt_wen ? ifa.rt_data : 1'b0, ifa.wk_valid, ifa.rf_addr, ifa.rt_addr,
                     ifa.wk_preg, ifa.rf_wen ? ifa.rf_data : 32'h0};
  assign raw_w[0] = {3'b0, ifr.rob_valid, ifr.rob_id, ifr.rf_wen, ifr.rt_wen, ifr.rt_data,
                     ifr.wk_valid, ifr.rf_addr, ifr.rt_addr, ifr.wk_preg, ifr.rf_data};
  assign raw_w[1] = {3'b0, ifa.rob_valid, ifa.rob_id, ifa.rf_wen, ifa.rt_wen, ifa.rt_data,
                     ifa.wk_valid, ifa.rf_addr, ifa.rt_addr, ifa.wk_preg, ifa.rf_data};

  typedef struct {
    logic [5:0]  id;
    logic        wen;
    logic [5:0]  preg;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[6][$];      // model queue for instance m, channel c at index m*3+c
  int          rr_m[2];
  logic [63:0] exp_w[2];
  logic [2:0]  exp_rdy[2];
  logic [2:0]  smp_rdy[2];
  int          tests = 0;
  int          fails = 0;
  int          kc[3];         // per-channel sequence number for held sources

  function automatic logic [63:0] pack_exp(input ent_t e);
    logic wr;
    wr = e.wen && (e.preg != 6'd0);
    return {3'b0, 1'b1, e.id, wr, wr, wr, wr, wr ? e.preg : 6'd0, wr ? e.preg : 6'd0,
            wr ? e.preg : 6'd0, wr ? e.data : 32'd0};
  endfunction

  task automatic model_update(input int m);
    int g, best, a, c;
    ent_t e;
    if (rst) begin
      for (int i = 0; i < 3; i++) mq[m*3+i].delete();
      rr_m[m] = 2; exp_rdy[m] = 3'b000; exp_w[m] = '0;
      return;
    end
    for (int i = 0; i < 3; i++) exp_rdy[m][i] = (mq[m*3+i].size() < DEPTH);
    if (flush) begin
      for (int i = 0; i < 3; i++) mq[m*3+i].delete();
      exp_w[m] = '0;
      return;
    end
    g = -1;
    if (m == 0) begin
      for (int k = 1; k <= 3; k++) begin
        c = (rr_m[m] + k) % 3;
        if (g < 0 && mq[m*3+c].size() > 0) g = c;
      end
    end else begin
      best = 64;
      for (int i = 0; i < 3; i++)
        if (mq[m*3+i].size() > 0) begin
          a = (int'(mq[m*3+i][0].id) - int'(nri) + 64) % 64;
          if (a < best) begin best = a; g = i; end
        end
    end
    if (g >= 0) begin
      e = mq[m*3+g].pop_front();
      exp_w[m] = pack_exp(e);
      rr_m[m] = g;
    end else exp_w[m] = '0;
    for (int i = 0; i < 3; i++)
      if (v[i] && exp_rdy[m][i]) begin
        e.id = rid[i*6 +: 6]; e.wen = wen[i]; e.preg = preg[i*6 +: 6]; e.data = data[i*32 +: 32];
        mq[m*3+i].push_back(e);
      end
  endtask

  task automatic step();
    #1;
    smp_rdy[0] = ifr.in_ready;
    smp_rdy[1] = ifa.in_ready;
    model_update(0);
    model_update(1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    v = '0; wen = '0; rid = '0; preg = '0; data = '0; flush = 1'b0;
  endtask

  task automatic set_ch(input int c, input logic [5:0] id, input logic w,
                        input logic [5:0] p, input logic [31:0] d);
    v[c] = 1'b1; rid[c*6 +: 6] = id; wen[c] = w; preg[c*6 +: 6] = p; data[c*32 +: 32] = d;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    nri = '0;
    rst = 1'b1;
    step();
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (smp_rdy[m] !== 3'b000) begin fails++; $display("FAIL reset_ready m=%0d got %b want 000", m, smp_rdy[m]); end
      tests++;
      if (raw_w[m] !== 64'h0) begin fails++; $display("FAIL reset_outputs m=%0d got %h want 0", m, raw_w[m]); end
    end
    rst = 1'b0;
    step();
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (smp_rdy[m] !== 3'b111) begin fails++; $display("FAIL post_reset_ready m=%0d got %b want 111", m, smp_rdy[m]); end
      tests++;
      if (raw_w[m] !== 64'h0) begin fails++; $display("FAIL post_reset_outputs m=%0d got %h want 0", m, raw_w[m]); end
    end
  endtask

  task automatic test_single();
    do_reset();
    set_ch(0, 6'd5, 1'b1, 6'd12, 32'hDEADBEEF);
    for (int t = 0; t < 3; t++) begin
      step();
      clear_inputs();
      for (int m = 0; m < 2; m++) begin
        tests++;
        if (obs_w[m] !== exp_w[m]) begin fails++; $display("FAIL single_model m=%0d t=%0d got %h want %h", m, t, obs_w[m], exp_w[m]); end
      end
      tests++;
      if (t == 1) begin
        if (!(ifr.rob_valid === 1'b1 && ifr.rob_id === 6'd5 && ifr.rf_wen === 1'b1 && ifr.rf_addr === 6'd12 &&
              ifr.rf_data === 32'hDEADBEEF && ifr.rt_wen === 1'b1 && ifr.rt_data === 1'b1 &&
              ifr.wk_valid === 1'b1 && ifr.wk_preg === 6'd12)) begin
          fails++; $display("FAIL single_commit got %h want valid id5 preg12 DEADBEEF", raw_w[0]);
        end
      end else if (ifr.rob_valid !== 1'b0) begin
        fails++; $display("FAIL single_latency t=%0d got rob_valid=%b want 0", t, ifr.rob_valid);
      end
    end
  endtask

  task automatic test_round_robin();
    int n;
    do_reset();
    n = 0;
    for (int c = 0; c < 3; c++) kc[c] = 0;
    for (int t = 0; t < 14; t++) begin
      for (int c = 0; c < 3; c++) set_ch(c, 6'(c*16 + kc[c]), 1'b1, 6'(c + 1), $urandom);
      step();
      for (int c = 0; c < 3; c++) if (exp_rdy[0][c]) kc[c]++;
      for (int m = 0; m < 2; m++) begin
        tests++;
        if (smp_rdy[m] !== exp_rdy[m]) begin fails++; $display("FAIL rr_ready m=%0d got %b want %b", m, smp_rdy[m], exp_rdy[m]); end
        tests++;
        if (obs_w[m] !== exp_w[m]) begin fails++; $display("FAIL rr_model m=%0d got %h want %h", m, obs_w[m], exp_w[m]); end
      end
      if (ifr.rob_valid === 1'b1) begin
        tests++;
        if (int'(ifr.rob_id) / 16 != n % 3) begin fails++; $display("FAIL rr_order n=%0d got ch%0d want ch%0d", n, int'(ifr.rob_id) / 16, n % 3); end
        n++;
      end
    end
    clear_inputs();
    tests++;
    if (n < 12) begin fails++; $display("FAIL rr_grants got %0d want >=12", n); end
  endtask

  task automatic test_oldest();
    logic [5:0] got[$];
    logic [5:0] want[3];
    want[0] = 6'd61; want[1] = 6'd62; want[2] = 6'd1;
    do_reset();
    nri = 6'd60;
    set_ch(0, 6'd62, 1'b1, 6'd3, 32'h1111);
    set_ch(1, 6'd1,  1'b1, 6'd4, 32'h2222);
    set_ch(2, 6'd61, 1'b1, 6'd5, 32'h3333);
    for (int t = 0; t < 5; t++) begin
      step();
      clear_inputs();
      for (int m = 0; m < 2; m++) begin
        tests++;
        if (obs_w[m] !== exp_w[m]) begin fails++; $display("FAIL oldest_model m=%0d got %h want %h", m, obs_w[m], exp_w[m]); end
      end
      if (ifa.rob_valid === 1'b1) got.push_back(ifa.rob_id);
    end
    tests++;
    if (got.size() != 3) begin fails++; $display("FAIL oldest_count got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      tests++;
      if (got[i] !== want[i]) begin fails++; $display("FAIL oldest_order i=%0d got %0d want %0d", i, got[i], want[i]); end
    end
    nri = '0;
  endtask

  task automatic test_backpressure();
    int seen[64];
    int full_at;
    for (int i = 0; i < 64; i++) seen[i] = 0;
    do_reset();
    nri = '0;
    kc[0] = 0; kc[1] = 0;
    full_at = -1;
    for (int t = 0; t < 24; t++) begin
      clear_inputs();
      if (kc[0] < 8) set_ch(0, 6'(1 + kc[0]), 1'b1, 6'd7, $urandom);
      if (kc[1] < 3) set_ch(1, 6'(40 + kc[1]), 1'b1, 6'd8, $urandom);
      step();
      if (t == full_at + 1 && full_at >= 0) begin
        tests++;
        if (smp_rdy[1][1] !== 1'b0) begin fails++; $display("FAIL bp_ready_drop got %b want 0", smp_rdy[1][1]); end
      end
      for (int c = 0; c < 2; c++) if (v[c] && exp_rdy[1][c]) kc[c]++;
      if (kc[1] == 2 && full_at < 0) full_at = t;
      for (int m = 0; m < 2; m++) begin
        tests++;
        if (obs_w[m] !== exp_w[m]) begin fails++; $display("FAIL bp_model m=%0d got %h want %h", m, obs_w[m], exp_w[m]); end
      end
      if (ifa.rob_valid === 1'b1) seen[ifa.rob_id]++;
    end
    clear_inputs();
    for (int i = 1; i <= 8; i++) begin
      tests++;
      if (seen[i] != 1) begin fails++; $display("FAIL bp_ch0_once id=%0d got %0d want 1", i, seen[i]); end
    end
    for (int i = 40; i <= 42; i++) begin
      tests++;
      if (seen[i] != 1) begin fails++; $display("FAIL bp_ch1_once id=%0d got %0d want 1", i, seen[i]); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 3; c++) kc[c] = 0;
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < 3; c++) set_ch(c, 6'(c*16 + kc[c]), 1'b1, 6'(c + 9), $urandom);
      step();
      for (int c = 0; c < 3; c++) if (exp_rdy[0][c]) kc[c]++;
    end
    tests++;
    if (ifr.rob_valid !== 1'b1) begin fails++; $display("FAIL flush_precond got rob_valid=%b want 1", ifr.rob_valid); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int m = 0; m < 2; m++) begin
      tests++;
      if (raw_w[m] !== 64'h0) begin fails++; $display("FAIL flush_outputs m=%0d got %h want 0", m, raw_w[m]); end
    end
    tests++;
    if (ifr.in_ready !== 3'b111 || ifa.in_ready !== 3'b111) begin
      fails++; $display("FAIL flush_ready got %b/%b want 111/111", ifr.in_ready, ifa.in_ready);
    end
    clear_inputs();
    for (int t = 0; t < 5; t++) begin
      step();
      tests++;
      if (ifr.rob_valid !== 1'b0 || ifa.rob_valid !== 1'b0) begin
        fails++; $display("FAIL flush_stale t=%0d got %b/%b want 0/0", t, ifr.rob_valid, ifa.rob_valid);
      end
    end
  endtask

  task automatic test_no_write();
    int nv;
    do_reset();
    nv = 0;
    set_ch(1, 6'd9, 1'b1, 6'd0, 32'hCAFE0001);
    for (int t = 0; t < 4; t++) begin
      step();
      clear_inputs();
      if (t == 0) set_ch(2, 6'd10, 1'b0, 6'd7, 32'hCAFE0002);
      for (int m = 0; m < 2; m++) begin
        tests++;
        if (obs_w[m] !== exp_w[m]) begin fails++; $display("FAIL nowr_model m=%0d got %h want %h", m, obs_w[m], exp_w[m]); end
      end
      if (ifr.rob_valid === 1'b1) begin
        tests++;
        if ({ifr.rf_wen, ifr.rt_wen, ifr.wk_valid} !== 3'b000 || ifr.rob_id !== 6'(9 + nv)) begin
          fails++; $display("FAIL nowr_commit got id=%0d wens=%b want id=%0d wens=000", ifr.rob_id,
                            {ifr.rf_wen, ifr.rt_wen, ifr.wk_valid}, 9 + nv);
        end
        nv++;
      end
    end
    tests++;
    if (nv != 2) begin fails++; $display("FAIL nowr_count got %0d want 2", nv); end
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 400; t++) begin
      for (int c = 0; c < 3; c++) begin
        v[c] = ($urandom_range(0, 3) != 0);
        rid[c*6 +: 6] = 6'($urandom);
        wen[c] = 1'($urandom);
        preg[c*6 +: 6] = 6'($urandom_range(0, 7));
        data[c*32 +: 32] = $urandom;
      end
      nri = 6'($urandom);
      flush = ($urandom_range(0, 31) == 0);
      step();
      for (int m = 0; m < 2; m++) begin
        tests++;
        if (smp_rdy[m] !== exp_rdy[m]) begin fails++; $display("FAIL rand_ready m=%0d t=%0d got %b want %b", m, t, smp_rdy[m], exp_rdy[m]); end
        tests++;
        if (obs_w[m] !== exp_w[m]) begin fails++; $display("FAIL rand_model m=%0d t=%0d got %h want %h", m, t, obs_w[m], exp_w[m]); end
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    nri = '0;
    rst = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_oldest();
    test_backpressure();
    test_flush();
    test_no_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
